// File: rtl/dds_carrier_combiner.sv
// N-channel signed carrier combiner: per-channel enable/sign, sum, width
// adaptation (saturate or wrap), two-stage valid/ready pipeline.
module dds_carrier_combiner #(
  parameter int N_CH     = 2,
  parameter int W_IN     = 8,
  parameter int W_OUT    = 17,
  parameter int SAT_MODE = 1
) (
  input  logic                   clk_dds,
  input  logic                   rst,
  input  logic [N_CH*W_IN-1:0]   s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH-1:0]        ch_neg,
  output logic [W_OUT-1:0]       m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   ovf_flag,
  input  logic                   ovf_clr
);

  localparam int CLG = (N_CH > 1) ? $clog2(N_CH) : 0;
  localparam int WS  = W_IN + 1 + CLG;

  logic signed [WS-1:0] s1_q [N_CH];
  logic signed [WS-1:0] s1_d [N_CH];
  logic                 v1_q;
  logic                 mv_q;
  logic [W_OUT-1:0]     md_q;
  logic                 ovf_q;
  logic signed [WS-1:0] sum;
  logic [W_OUT-1:0]     red;
  logic                 oor;
  logic                 adv2;

  assign adv2     = !mv_q || m_tready;
  assign s_tready = !v1_q || adv2;
  assign m_tvalid = mv_q;
  assign m_tdata  = md_q;
  assign ovf_flag = ovf_q;

  // The extra sum bit lets -(-2^(W_IN-1)) be represented exactly
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      s1_d[k] = '0;
      if (ch_en[k]) begin
        if (ch_neg[k])
          s1_d[k] = -WS'($signed(s_tdata[k*W_IN +: W_IN]));
        else
          s1_d[k] = WS'($signed(s_tdata[k*W_IN +: W_IN]));
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum = sum + s1_q[k];
    end
  end

  generate
    if (W_OUT >= WS) begin : g_ext
      assign red = W_OUT'(sum);
      assign oor = 1'b0;
    end else begin : g_red
      localparam logic signed [WS-1:0] MAXV =
        {{(WS-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
      localparam logic signed [WS-1:0] MINV = ~MAXV;
      localparam logic [W_OUT-1:0] SATMAX = {1'b0, {(W_OUT-1){1'b1}}};
      localparam logic [W_OUT-1:0] SATMIN = {1'b1, {(W_OUT-1){1'b0}}};
      assign oor = (sum > MAXV) || (sum < MINV);
      if (SAT_MODE != 0) begin : g_sat
        assign red = !oor ? sum[W_OUT-1:0]
                   : (sum[WS-1] ? SATMIN : SATMAX);
      end else begin : g_wrap
        assign red = sum[W_OUT-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      s1_q  <= '{default: '0};
      v1_q  <= 1'b0;
      mv_q  <= 1'b0;
      md_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (s_tready) begin
        v1_q <= s_tvalid;
        if (s_tvalid) s1_q <= s1_d;
      end
      if (adv2) begin
        mv_q <= v1_q;
        if (v1_q) md_q <= red;
      end
      // A new overflow takes priority over a clear in the same cycle
      if (adv2 && v1_q && oor)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dds_carrier_combiner.sv
// Bench for dds_carrier_combiner: three builds (17-bit extend, 8-bit
// saturate, 8-bit wrap) on shared stimulus, table + scoreboard checks.
module tb_dds_carrier_combiner;

  logic clk_dds = 1'b0;
  always #5 clk_dds = ~clk_dds;

  logic        rst;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic [1:0]  ch_en, ch_neg;
  logic        m_tready, ovf_clr;

  logic              sr17, sr8s, sr8w;
  logic signed [16:0] m17;
  logic signed [7:0]  m8s, m8w;
  logic              mv17, mv8s, mv8w;
  logic              of17, of8s, of8w;

  dds_carrier_combiner #(.N_CH(2), .W_IN(8), .W_OUT(17), .SAT_MODE(1)) u17 (
    .clk_dds(clk_dds), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(sr17), .ch_en(ch_en), .ch_neg(ch_neg), .m_tdata(m17),
    .m_tvalid(mv17), .m_tready(m_tready), .ovf_flag(of17), .ovf_clr(ovf_clr));

  dds_carrier_combiner #(.N_CH(2), .W_IN(8), .W_OUT(8), .SAT_MODE(1)) u8s (
    .clk_dds(clk_dds), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(sr8s), .ch_en(ch_en), .ch_neg(ch_neg), .m_tdata(m8s),
    .m_tvalid(mv8s), .m_tready(m_tready), .ovf_flag(of8s), .ovf_clr(ovf_clr));

  dds_carrier_combiner #(.N_CH(2), .W_IN(8), .W_OUT(8), .SAT_MODE(0)) u8w (
    .clk_dds(clk_dds), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(sr8w), .ch_en(ch_en), .ch_neg(ch_neg), .m_tdata(m8w),
    .m_tvalid(mv8w), .m_tready(m_tready), .ovf_flag(of8w), .ovf_clr(ovf_clr));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic
  function automatic int term(input int x, input bit en, input bit ng);
    if (!en) return 0;
    return ng ? -x : x;
  endfunction

  function automatic int model_sum(input int a, input int b,
                                   input logic [1:0] en,
                                   input logic [1:0] ng);
    return term(a, en[0], ng[0]) + term(b, en[1], ng[1]);
  endfunction

  function automatic int sat8(input int s);
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  function automatic int wrap8(input int s);
    int r;
    r = s & 255;
    if (r >= 128) r = r - 256;
    return r;
  endfunction

  function automatic bit oor8(input int s);
    return (s > 127) || (s < -128);
  endfunction

  task automatic drive(input int a, input int b, input logic [1:0] en,
                       input logic [1:0] ng, input logic v);
    logic [31:0] av, bv;
    av = a;
    bv = b;
    s_tdata  = {bv[7:0], av[7:0]};
    ch_en    = en;
    ch_neg   = ng;
    s_tvalid = v;
  endtask

  task automatic step();
    @(posedge clk_dds);
    #1;
  endtask

  typedef struct {
    int         a;
    int         b;
    logic [1:0] en;
    logic [1:0] ng;
    int         e17;
    int         e8s;
    int         e8w;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  int  q[$];
  int  sent, got, cyc, a, b, ps, ex;
  bit  held, acc, ovf_exp;
  int  h17, h8s, h8w;
  logic [1:0] ren, rng;

  initial begin
    tbl[0] = '{127, 127, 2'b11, 2'b00, 254, 127, -2};
    tbl[1] = '{-128, -128, 2'b11, 2'b00, -256, -128, 0};
    tbl[2] = '{5, -3, 2'b11, 2'b00, 2, 2, 2};
    tbl[3] = '{-128, 0, 2'b11, 2'b01, 128, 127, -128};
    tbl[4] = '{50, 7, 2'b10, 2'b00, 7, 7, 7};
    tbl[5] = '{100, 100, 2'b11, 2'b00, 200, 127, -56};
    tbl[6] = '{-100, -100, 2'b11, 2'b00, -200, -128, 56};

    rst = 1'b1;
    m_tready = 1'b1;
    ovf_clr = 1'b0;
    drive(0, 0, 2'b00, 2'b00, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_mvalid", mv17, 0);
    chk("rst_sready", sr17, 1);
    chk("rst_ovf8", of8s, 0);
    chk("rst_mdata", m17, 0);

    // Back-to-back table vectors, outputs checked two cycles later
    ovf_exp = 1'b0;
    for (int i = 0; i <= NV; i++) begin
      if (i < NV)
        drive(tbl[i].a, tbl[i].b, tbl[i].en, tbl[i].ng, 1'b1);
      else
        drive(0, 0, 2'b11, 2'b00, 1'b0);
      #1;
      chk("tbl_sready", sr17, 1);
      step();
      if (i == 0) begin
        chk("tbl_latency", mv17, 0);
      end else begin
        ovf_exp = ovf_exp | oor8(tbl[i-1].e17);
        chk("tbl_mvalid", mv17, 1);
        chk("tbl_out17", m17, tbl[i-1].e17);
        chk("tbl_out8s", m8s, tbl[i-1].e8s);
        chk("tbl_out8w", m8w, tbl[i-1].e8w);
        chk("tbl_model8s", m8s, sat8(tbl[i-1].e17));
        chk("tbl_ovf17", of17, 0);
        chk("tbl_ovf8s", of8s, int'(ovf_exp));
        chk("tbl_ovf8w", of8w, int'(ovf_exp));
      end
    end
    step();
    chk("tbl_drained", mv17, 0);

    // Clear, then overflow and clear landing in the same cycle
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_ovf8s", of8s, 0);
    chk("clr_ovf8w", of8w, 0);
    drive(100, 100, 2'b11, 2'b00, 1'b1);
    step();
    s_tvalid = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("setwins_ovf8s", of8s, 1);
    chk("setwins_ovf8w", of8w, 1);
    chk("setwins_out8s", m8s, 127);
    chk("setwins_out8w", m8w, -56);
    chk("setwins_ovf17", of17, 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr2_ovf8s", of8s, 0);

    // Ramp then random samples under random backpressure
    sent = 0;
    got = 0;
    cyc = 0;
    held = 1'b0;
    ps = 0;
    s_tvalid = 1'b0;
    while ((sent < 40 || q.size() > 0) && cyc < 600) begin
      m_tready = 1'($urandom_range(0, 1));
      if (!s_tvalid && sent < 40 && $urandom_range(0, 3) != 0) begin
        if (sent < 10) begin
          a = sent * 25 - 128;
          b = sent * 3;
          ren = 2'b11;
          rng = 2'b00;
        end else begin
          a = $urandom_range(0, 255) - 128;
          b = $urandom_range(0, 255) - 128;
          ren = 2'($urandom_range(0, 3));
          rng = 2'($urandom_range(0, 3));
        end
        ps = model_sum(a, b, ren, rng);
        drive(a, b, ren, rng, 1'b1);
      end
      #1;
      if (held) begin
        chk("stall_mvalid", mv17, 1);
        chk("stall_hold17", m17, h17);
        chk("stall_hold8s", m8s, h8s);
        chk("stall_hold8w", m8w, h8w);
      end
      if (mv17 && m_tready) begin
        if (q.size() == 0) begin
          chk("bp_spurious", 1, 0);
        end else begin
          ex = q.pop_front();
          got++;
          chk("bp_out17", m17, ex);
          chk("bp_out8s", m8s, sat8(ex));
          chk("bp_out8w", m8w, wrap8(ex));
        end
      end
      held = mv17 && !m_tready;
      h17 = m17;
      h8s = m8s;
      h8w = m8w;
      acc = s_tvalid && sr17;
      if (acc) begin
        q.push_back(ps);
        sent++;
      end
      if (q.size() > 2) chk("bp_inflight", q.size(), 2);
      step();
      if (acc) s_tvalid = 1'b0;
      cyc++;
    end
    chk("bp_timeout", int'(cyc < 600), 1);
    chk("bp_count", got, 40);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    step();
    step();

    // Reset with two samples in flight
    m_tready = 1'b0;
    drive(10, 20, 2'b11, 2'b00, 1'b1);
    step();
    drive(30, 40, 2'b11, 2'b00, 1'b1);
    step();
    s_tvalid = 1'b0;
    chk("full_mvalid", mv17, 1);
    chk("full_sready", sr17, 0);
    rst = 1'b1;
    #1;
    chk("rstmid_mvalid", mv17, 0);
    chk("rstmid_sready", sr17, 1);
    step();
    rst = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstmid_nostale", mv17, 0);
    end
    drive(-7, 3, 2'b11, 2'b00, 1'b1);
    step();
    s_tvalid = 1'b0;
    chk("after_rst_lat", mv17, 0);
    step();
    chk("after_rst_mvalid", mv17, 1);
    chk("after_rst_out17", m17, -4);
    step();
    chk("after_rst_done", mv17, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
